// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the fpu arbiter.
// State encoding, op codes and the error result word.
package fpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4,
        S_ERR       = 3'd5,
        S_DRAIN     = 3'd6
    } state_e;

    localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;
    localparam logic        OP_ADD   = 1'b0;
    localparam logic        OP_SUB   = 1'b1;

endpackage

// File: rtl/fpu_rr_pick.sv
// Rotate-priority pick: first valid requester after rr_ptr,
// wrapping, so rr_ptr itself has the lowest priority.
module fpu_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit is kept.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpu between requesters,
// with a watchdog that reports a hung fpu as a tagged error response.
module fpu_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_grant,
    output logic                rsp_valid,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                fpu_start,
    output logic                fpu_op,
    output logic [31:0]         fpu_a,
    output logic [31:0]         fpu_b,
    input  logic                fpu_ready,
    input  logic [31:0]         fpu_c
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              start_q, start_d;
    logic              rv_q, rv_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic              wd_hit;
    logic [31:0]       a_arr [N_REQ];
    logic [31:0]       b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[32*g +: 32];
        assign b_arr[g] = req_b[32*g +: 32];
    end

    fpu_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_q),
        .found     (found),
        .idx       (pick)
    );

    assign wd_hit = (wdog_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        wdog_d  = wdog_q;
        grant_d = '0;
        start_d = 1'b0;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (found && fpu_ready) begin
                    grant_d = N_REQ'(1) << pick;
                    rr_d    = pick;
                    id_d    = pick;
                    op_d    = req_op[pick];
                    a_d     = a_arr[pick];
                    b_d     = b_arr[pick];
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!fpu_ready) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_DONE;
                end else if (wd_hit) begin
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    data_d  = FPU_QNAN;
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (fpu_ready) begin
                    rv_d    = 1'b1;
                    data_d  = fpu_c;
                    state_d = S_RESP;
                end else if (wd_hit) begin
                    rv_d    = 1'b1;
                    err_d   = 1'b1;
                    data_d  = FPU_QNAN;
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_DRAIN;
            S_DRAIN: begin
                if (fpu_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            wdog_q  <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wdog_q  <= wdog_d;
            grant_q <= grant_d;
            start_q <= start_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign req_grant = grant_q;
    assign rsp_valid = rv_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != S_IDLE);
    assign fpu_start = start_q;
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;

endmodule
